lifo_stack_param: RTL

- Parametrised LIFO stack for the lab datapath; supersedes the fixed 4-bit x 8 stack.
- Adds configurable width and depth, a live occupancy count, an almost-full flag and a registered pop-data valid strobe.
- Adds simultaneous push+pop (replace-top), a synchronous clear, and sticky overflow/underflow error flags.
- Sits between a producer/consumer pair that issues single-cycle push/pop requests.

---
 rtl/lifo_pkg.sv | 25 ++
 rtl/lifo_mem.sv | 25 ++
 rtl/lifo_stack_param.sv | 105 ++++++++++
 3 files changed

// File: rtl/lifo_pkg.sv
// rtl/lifo_pkg.sv - shared types and width helper for the parametrised LIFO stack
package lifo_pkg;

  typedef enum logic [2:0] {
    OP_NONE    = 3'd0,
    OP_PUSH    = 3'd1,
    OP_POP     = 3'd2,
    OP_REPLACE = 3'd3,
    OP_CLEAR   = 3'd4
  } op_t;

  // Ceiling log2 for widths. Callers always pass n >= 2, so the result is at least 1.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lifo_mem.sv
// rtl/lifo_mem.sv - unreset register array, one synchronous write and one combinational read port
module lifo_mem
  import lifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack_param.sv
// rtl/lifo_stack_param.sv - parametrised LIFO with occupancy count, replace-top, clear and sticky errors
module lifo_stack_param
  import lifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = 14
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              push,
  input  logic                              pop,
  input  logic [WIDTH-1:0]                  data_in,
  input  logic                              err_clr,
  output logic [WIDTH-1:0]                  pop_data,
  output logic                              pop_valid,
  output logic [lifo_pkg::clog2(DEPTH+1)-1:0] count,
  output logic                              empty,
  output logic                              full,
  output logic                              almost_full,
  output logic                              overflow,
  output logic                              underflow
);

  localparam int CW = clog2(DEPTH + 1);
  localparam int AW = clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

  op_t              op;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [AW-1:0]    top_idx;
  logic [WIDTH-1:0] top_data;
  logic             ovf_set;
  logic             unf_set;

  assign empty       = (count == '0);
  assign full        = (count == DEPTH_C);
  assign almost_full = (count >= AFULL_C);

  // Low bits suffice: count==DEPTH wraps to 0 here and minus one lands on DEPTH-1.
  assign top_idx = count[AW-1:0] - AW'(1);

  // A push+pop on an empty stack degenerates to a plain push.
  always_comb begin
    op = OP_NONE;
    if (clear)                op = OP_CLEAR;
    else if (push && pop)     op = empty ? OP_PUSH : OP_REPLACE;
    else if (push)            op = OP_PUSH;
    else if (pop)             op = OP_POP;
  end

  assign mem_we    = ((op == OP_PUSH) && !full) || (op == OP_REPLACE);
  assign mem_waddr = (op == OP_REPLACE) ? top_idx : count[AW-1:0];
  assign ovf_set   = (op == OP_PUSH) && full;
  assign unf_set   = (op == OP_POP) && empty;

  lifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (data_in),
    .raddr (top_idx),
    .rdata (top_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count     <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pop_valid <= 1'b0;
      overflow  <= ovf_set | (overflow & ~err_clr);
      underflow <= unf_set | (underflow & ~err_clr);
      case (op)
        OP_CLEAR: count <= '0;
        OP_PUSH: begin
          if (!full) count <= count + CW'(1);
        end
        OP_POP: begin
          if (!empty) begin
            pop_data  <= top_data;
            pop_valid <= 1'b1;
            count     <= count - CW'(1);
          end
        end
        OP_REPLACE: begin
          pop_data  <= top_data;
          pop_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
